// File: rtl/buzzer_pkg.sv
// buzzer_pkg: shared widths, FSM states, volume codes, note periods and duty helper for the buzzer path
package buzzer_pkg;
  localparam int PERIOD_W = 20;
  localparam int VOL_W = 2;
  localparam logic [PERIOD_W-1:0] MIN_PERIOD = 20'd2;
  typedef enum logic {IDLE, PLAY} state_t;
  localparam logic [VOL_W-1:0] VOL_HALF = 2'd3;
  localparam logic [VOL_W-1:0] VOL_QUARTER = 2'd2;
  localparam logic [VOL_W-1:0] VOL_EIGHTH = 2'd1;
  localparam logic [VOL_W-1:0] VOL_SIXTEENTH = 2'd0;
  localparam logic [PERIOD_W-1:0] NOTE_REST = 20'd0;
  localparam logic [PERIOD_W-1:0] NOTE_C4 = 20'd191131;
  localparam logic [PERIOD_W-1:0] NOTE_D4 = 20'd170265;
  localparam logic [PERIOD_W-1:0] NOTE_E4 = 20'd151685;
  localparam logic [PERIOD_W-1:0] NOTE_F4 = 20'd143172;
  localparam logic [PERIOD_W-1:0] NOTE_G4 = 20'd127551;
  localparam logic [PERIOD_W-1:0] NOTE_A4 = 20'd113636;
  localparam logic [PERIOD_W-1:0] NOTE_B4 = 20'd101239;
  localparam logic [PERIOD_W-1:0] NOTE_C5 = 20'd95557;
  // high phase length: period scaled by 1/2..1/16, never shorter than one cycle
  function automatic logic [PERIOD_W-1:0] duty_high(input logic [PERIOD_W-1:0] p, input logic [VOL_W-1:0] v);
    logic [PERIOD_W-1:0] h;
    h = p >> (3'd4 - {1'b0, v});
    return (h == '0) ? {{(PERIOD_W-1){1'b0}}, 1'b1} : h;
  endfunction
endpackage

// File: rtl/buzzer_pwm.sv
// buzzer_pwm: square-wave piezo drive from a tone period word, duty set by volume, updates only at period boundaries
// clk, rst: clock and synchronous active-high reset
// en, period, volume: play enable, tone period in cycles (below MIN_PERIOD = rest), duty code
// pwm_out: registered buzzer drive; period_done: pulse after each completed period; active: high in PLAY
module buzzer_pwm
  import buzzer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  input  logic [VOL_W-1:0]    volume,
  output logic                pwm_out,
  output logic                period_done,
  output logic                active
);
  state_t state, state_n;
  logic [PERIOD_W-1:0] cnt, cnt_n, cur_period, cur_n, high_time, high_n;
  logic pwm_n, done_n, load, wrap;
  assign load = en && (period >= MIN_PERIOD);
  assign wrap = cnt == cur_period - PERIOD_W'(1);
  always_comb begin
    state_n = state;
    cnt_n = '0;
    cur_n = cur_period;
    high_n = high_time;
    pwm_n = 1'b0;
    done_n = 1'b0;
    if (state == IDLE) begin
      if (load) begin
        cur_n = period;
        high_n = duty_high(period, volume);
        state_n = PLAY;
      end
    end else begin
      pwm_n = cnt < high_time;
      cnt_n = wrap ? '0 : cnt + PERIOD_W'(1);
      done_n = wrap;
      // inputs are only honoured at the wrap edge so a tone change never splits a cycle
      if (wrap && load) begin
        cur_n = period;
        high_n = duty_high(period, volume);
      end
      if (wrap && !load) state_n = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cur_period <= '0;
      high_time <= '0;
      pwm_out <= 1'b0;
      period_done <= 1'b0;
      active <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      cur_period <= cur_n;
      high_time <= high_n;
      pwm_out <= pwm_n;
      period_done <= done_n;
      active <= state_n == PLAY;
    end
  end
endmodule

// File: doc/buzzer_pwm.md
# buzzer_pwm

Downstream stage of the tune decoder. Converts the 20-bit tone period word (full tone period in clock cycles at 50 MHz, 0 = rest) into a square-wave drive for the piezo buzzer, with selectable duty for volume. New period and volume are accepted only at period boundaries, so tone changes are glitch-free. Output feeds the buzzer pin directly. A per-period strobe is provided for the upstream score sequencer.

## Interface
- PERIOD_W, 20: width of the period word and internal counter.
- VOL_W, 2: width of the volume code.
- MIN_PERIOD, 2: smallest period treated as a tone; values below it are rests.

- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- en  in  1  play enable; 0 forces silence at the next boundary.
- period  in  PERIOD_W  tone period in clk cycles, straight from the tune decoder; 0 = rest.
- volume  in  VOL_W  duty code: 3 = 1/2, 2 = 1/4, 1 = 1/8, 0 = 1/16.
- pwm_out  out  1  registered buzzer drive.
- period_done  out  1  one-cycle pulse at each completed tone period.
- active  out  1  high while in PLAY.

## Operation
- States: IDLE and PLAY.
- Registers: cur_period (PERIOD_W), high_time (PERIOD_W), cnt (PERIOD_W), state.
- Reset values: state=IDLE, cnt=0, cur_period=0, high_time=0, pwm_out=0, period_done=0, active=0.
- `load` condition: en=1 and period ≥ MIN_PERIOD.
- IDLE:
  - pwm_out is driven 0 and cnt is held at 0.
  - If `load` holds at a clock edge:
    - cur_period ← period.
    - high_time ← max(1, period >> (4 − volume)).
    - cnt ← 0.
    - state ← PLAY.
- PLAY:
  - Each edge: pwm_out ← (cnt < high_time).
  - If cnt ≠ cur_period−1: cnt ← cnt+1.
  - If cnt = cur_period−1 (the wrap edge):
    - cnt ← 0.
    - period_done ← 1.
    - period and volume are sampled. If `load` holds, reload cur_period and high_time, stay in PLAY. Otherwise state ← IDLE.
- Changes on period, volume or en away from the wrap edge have no effect until the next wrap.
  - Silence is delayed by at most one period (≤ 3.83 ms at 261.6 Hz).
- The last pwm_out value written at a wrap edge is always 0, because cnt = cur_period−1 ≥ high_time. Stopping never truncates a high phase.
- Same period re-sampled at a wrap: counting continues seamlessly, with no extra cycle and no phase reset.
- active = (state == PLAY), registered together with state.
- Arithmetic:
  - The counter never exceeds cur_period−1, so there is no overflow.
  - high_time < cur_period for every period ≥ 2.

## Timing
- Edge E0: IDLE samples `load`. After E0: PLAY, cnt=0, active=1.
- Edge E1: pwm_out ← 1. First high level is visible 1 cycle after active rises.
- pwm_out is high for exactly high_time cycles and low for cur_period−high_time cycles.
- Output period is exactly cur_period cycles.
- period_done is high for the single cycle after each wrap edge, i.e. coincident with cnt=0 of the next period or with the first IDLE cycle.
- rst=1 at any edge forces all reset values on that edge, including mid-period. pwm_out is 0 on the following cycle.

## Structure
- Shared package buzzer_pkg holds:
  - PERIOD_W.
  - MIN_PERIOD.
  - the state enum {IDLE, PLAY}.
  - the volume-code constants.
- The tune decoder's period constants move into the same package.
- Single flat module; no sub-module warranted. The duty shift is a small combinational function in the package.

## Test plan
- Reset, then en=1, period=10, volume=3:
  - active rises 1 cycle after the sampling edge.
  - pwm_out repeats 5 cycles high, 5 low.
  - period_done pulses every 10 cycles.
- period=16, volume=0:
  - high_time=1, so 1 high / 15 low.
  - Then period=3, volume=0: high_time forced to 1, so 1 high / 2 low.
- While playing period=10, switch to period=20 at cnt=3:
  - The current period completes at 10 cycles.
  - The next is 10 high / 10 low, with no short or long pulse at the seam.
- Drop en at cnt=2 (volume=3, period=10):
  - pwm_out finishes 5 high / 5 low.
  - Then IDLE with pwm_out=0 and active=0; period_done pulses once.
- period=1 or period=0 with en=1: stays IDLE, pwm_out=0, no period_done.
- Real tone 0x1BBE4 (113636 cycles, 440 Hz), volume=3:
  - 56818 high / 56818 low.
  - rst asserted mid-high-phase gives pwm_out=0, active=0, cnt=0 on the next cycle.
